// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Buffers writeback requests from the load path and the ALU path and drives
// the register file's single write port one entry per cycle. The load path
// has strict priority; requests to register 0 are accepted but discarded.
// Combinational pending flags report registers with writes still in flight
// (queued or sitting in the registered write-port stage).
//
// Optional feature: define WB_FORWARD_EN to add fwd_data1/fwd_data2, which
// carry the data of the youngest in-flight write to each queried register.
//
// Handshake: a request transfers on a posedge where its valid and ready are
// both high; ready depends only on current occupancy (and, for the ALU port,
// on mem_valid), never on whether a pop happens in the same cycle.
module reg_writeback_queue #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [REG_NUM_BITWIDTH-1:0] alu_rd,
    input  logic [WORD_BITWIDTH-1:0]    alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [REG_NUM_BITWIDTH-1:0] mem_rd,
    input  logic [WORD_BITWIDTH-1:0]    mem_data,
    output logic [REG_NUM_BITWIDTH-1:0] regToWrite,
    output logic [WORD_BITWIDTH-1:0]    write_data,
    output logic                        doRegWrite,
    input  logic [REG_NUM_BITWIDTH-1:0] query_rd1,
    input  logic [REG_NUM_BITWIDTH-1:0] query_rd2,
    output logic                        pending1,
    output logic                        pending2,
`ifdef WB_FORWARD_EN
    output logic [WORD_BITWIDTH-1:0]    fwd_data1,
    output logic [WORD_BITWIDTH-1:0]    fwd_data2,
`endif
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage (contents are only meaningful inside the occupied window)
    logic [REG_NUM_BITWIDTH-1:0] ent_rd_q   [DEPTH];
    logic [WORD_BITWIDTH-1:0]    ent_data_q [DEPTH];

    logic [PTR_W-1:0]            wptr_q, wptr_d;
    logic [PTR_W-1:0]            rptr_q, rptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // Registered write-port stage
    logic                        out_vld_q, out_vld_d;
    logic [REG_NUM_BITWIDTH-1:0] out_rd_q, out_rd_d;
    logic [WORD_BITWIDTH-1:0]    out_data_q, out_data_d;

    logic                        full;
    logic                        push;
    logic                        enq;
    logic                        pop;
    logic [REG_NUM_BITWIDTH-1:0] push_rd;
    logic [WORD_BITWIDTH-1:0]    push_data;

    logic                        hit1, hit2;
    logic [PTR_W-1:0]            scan_idx;
`ifdef WB_FORWARD_EN
    logic [WORD_BITWIDTH-1:0]    fwd1, fwd2;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    // Select the accepted request and decide whether it occupies an entry
    always_comb begin
        push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
        push_rd   = mem_valid ? mem_rd   : alu_rd;
        push_data = mem_valid ? mem_data : alu_data;
        enq       = push && (push_rd != '0);
        pop       = (count_q != '0);
    end

    // Next-state for pointers, occupancy and the write-port stage
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
        out_vld_d  = pop;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        if (enq) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            out_rd_d   = ent_rd_q[rptr_q];
            out_data_d = ent_data_q[rptr_q];
            rptr_d     = rptr_q + 1'b1;
        end
    end

    // Control state with synchronous reset; reset drops every queued write
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            out_vld_q  <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            out_vld_q  <= out_vld_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

    // Entry storage write; no reset needed since occupancy gates all reads
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            ent_rd_q[wptr_q]   <= push_rd;
            ent_data_q[wptr_q] <= push_data;
        end
    end

    // Pending/forward scan: output stage first, then entries oldest to
    // youngest so the youngest match wins the forwarded data
    always_comb begin
        hit1     = out_vld_q && (out_rd_q == query_rd1);
        hit2     = out_vld_q && (out_rd_q == query_rd2);
        scan_idx = rptr_q;
`ifdef WB_FORWARD_EN
        fwd1 = out_data_q;
        fwd2 = out_data_q;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (ent_rd_q[scan_idx] == query_rd1) begin
                    hit1 = 1'b1;
`ifdef WB_FORWARD_EN
                    fwd1 = ent_data_q[scan_idx];
`endif
                end
                if (ent_rd_q[scan_idx] == query_rd2) begin
                    hit2 = 1'b1;
`ifdef WB_FORWARD_EN
                    fwd2 = ent_data_q[scan_idx];
`endif
                end
            end
        end
        pending1 = hit1 && (query_rd1 != '0);
        pending2 = hit2 && (query_rd2 != '0);
`ifdef WB_FORWARD_EN
        fwd_data1 = pending1 ? fwd1 : '0;
        fwd_data2 = pending2 ? fwd2 : '0;
`endif
    end

    assign doRegWrite = out_vld_q;
    assign regToWrite = out_rd_q;
    assign write_data = out_data_q;
    assign count      = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Testbench for reg_writeback_queue: directed scenarios followed by random
// traffic, each cycle compared against a queue-based behavioural model.
module tb_reg_writeback_queue;

    localparam int RW    = 5;
    localparam int WW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready;
    logic [RW-1:0] alu_rd;
    logic [WW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [RW-1:0] mem_rd;
    logic [WW-1:0] mem_data;
    logic [RW-1:0] regToWrite;
    logic [WW-1:0] write_data;
    logic          doRegWrite;
    logic [RW-1:0] query_rd1, query_rd2;
    logic          pending1, pending2;
    logic [CW-1:0] count;
`ifdef WB_FORWARD_EN
    logic [WW-1:0] fwd_data1, fwd_data2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: queued writes in acceptance order plus the write-port stage
    logic [RW+WW-1:0] exp_q[$];
    logic             m_out_v    = 1'b0;
    logic [RW-1:0]    m_out_rd   = '0;
    logic [WW-1:0]    m_out_data = '0;

    reg_writeback_queue #(
        .REG_NUM_BITWIDTH(RW),
        .WORD_BITWIDTH(WW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .regToWrite(regToWrite),
        .write_data(write_data),
        .doRegWrite(doRegWrite),
        .query_rd1(query_rd1),
        .query_rd2(query_rd2),
        .pending1(pending1),
        .pending2(pending2),
`ifdef WB_FORWARD_EN
        .fwd_data1(fwd_data1),
        .fwd_data2(fwd_data2),
`endif
        .count(count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_pending(input logic [RW-1:0] q);
        if (q == '0) return 1'b0;
        if (m_out_v && m_out_rd == q) return 1'b1;
        foreach (exp_q[i]) if (exp_q[i][RW+WW-1:WW] == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [WW-1:0] m_fwd(input logic [RW-1:0] q);
        logic [WW-1:0] r;
        r = '0;
        if (!m_pending(q)) return '0;
        if (m_out_v && m_out_rd == q) r = m_out_data;
        foreach (exp_q[i]) if (exp_q[i][RW+WW-1:WW] == q) r = exp_q[i][WW-1:0];
        return r;
    endfunction

    // Drive one cycle of inputs, check all outputs against the model, then
    // advance the model across the coming posedge.
    task automatic step(input logic r,
                        input logic av, input logic [RW-1:0] ard, input logic [WW-1:0] ad,
                        input logic mv, input logic [RW-1:0] mrd, input logic [WW-1:0] md,
                        input logic [RW-1:0] q1, input logic [RW-1:0] q2);
        logic             full;
        logic [RW+WW-1:0] e;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        query_rd1 = q1; query_rd2 = q2;
        #1;
        full = (exp_q.size() == DEPTH);
        check("count",      32'(count),      32'(exp_q.size()));
        check("doRegWrite", 32'(doRegWrite), 32'(m_out_v));
        check("regToWrite", 32'(regToWrite), 32'(m_out_rd));
        check("write_data", write_data,      m_out_data);
        check("mem_ready",  32'(mem_ready),  32'(!full));
        check("alu_ready",  32'(alu_ready),  32'(!full && !mv));
        check("pending1",   32'(pending1),   32'(m_pending(q1)));
        check("pending2",   32'(pending2),   32'(m_pending(q2)));
`ifdef WB_FORWARD_EN
        check("fwd_data1",  fwd_data1,       m_fwd(q1));
        check("fwd_data2",  fwd_data2,       m_fwd(q2));
`endif
        if (r) begin
            exp_q.delete();
            m_out_v = 1'b0; m_out_rd = '0; m_out_data = '0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_out_v = 1'b1;
                m_out_rd = e[RW+WW-1:WW];
                m_out_data = e[WW-1:0];
            end else begin
                m_out_v = 1'b0;
            end
            if (!full) begin
                if (mv) begin
                    if (mrd != '0) exp_q.push_back({mrd, md});
                end else if (av && ard != '0) begin
                    exp_q.push_back({ard, ad});
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic [RW-1:0] q1, input logic [RW-1:0] q2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, q1, q2);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        query_rd1 = '0; query_rd2 = '0;
        repeat (2) @(posedge clk);

        // Reset, then idle
        idle(5, 5'd0, 5'd9);

        // Single ALU write, watched through pending1
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, 5'd6);
        idle(4, 5'd5, 5'd6);

        // Both valid: load first, ALU the following cycle
        step(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4, 5'd3, 5'd4);
        step(1'b0, 1'b1, 5'd3, 32'hA3, 1'b0, '0, '0, 5'd3, 5'd4);
        idle(4, 5'd3, 5'd4);

        // Five back-to-back loads
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 5'(i), 32'(i * 16'h111), 5'(i), 5'd1);
        idle(4, 5'd5, 5'd3);

        // Register 0 is dropped
        step(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 5'd0, 5'd0);
        idle(3, 5'd0, 5'd0);

        // Two writes to rd 7, then reset mid-operation
        step(1'b0, 1'b1, 5'd7, 32'h10, 1'b0, '0, '0, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h20, 1'b0, '0, '0, 5'd7, 5'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, 32'h30, 5'd7, 5'd8);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd8);
        idle(4, 5'd7, 5'd8);

        // Random traffic with small register range to force collisions
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(4, 5'd1, 5'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
